// File: rtl/seg7_mux_ctrl_n_if.sv
// Control, display-data and pin-side signals of the N-digit multiplexed 7-segment controller.
// No handshake: all inputs are levels or single-cycle strobes, and all outputs are free-running.
interface seg7_mux_ctrl_n_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    load_pls;
    logic                    freeze;
    logic                    hex_mode;
    logic                    lzb_en;
    logic                    dim_up_pls;
    logic                    dim_dwn_pls;
    logic [4*NUM_DIGITS-1:0] x;
    logic [NUM_DIGITS-1:0]   x_dp;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [3:0]              dim_val;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output en, load_pls, freeze, hex_mode, lzb_en, dim_up_pls, dim_dwn_pls,
        output x, x_dp, blink_mask,
        input  dim_val, seg, dp, an
    );

    modport slave (
        input  en, load_pls, freeze, hex_mode, lzb_en, dim_up_pls, dim_dwn_pls,
        input  x, x_dp, blink_mask,
        output dim_val, seg, dp, an
    );
endinterface

// File: rtl/seg7_mux_ctrl_n.sv
// N-digit multiplexed 7-segment driver: latched display, PWM dimming, ghost blanking, blink, LZB.
// an/seg/dp are registered one clock after the scan state; there is no backpressure (strobes act at once).
module seg7_mux_ctrl_n #(
    parameter int NUM_DIGITS    = 4,
    parameter int CLOCK_FREQ_HZ = 100_000_000,
    parameter int UPDATE_MS     = 300,
    parameter int BLINK_MS      = 250,
    parameter int SCAN_BITS     = 18,
    parameter int BLANK_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_mux_ctrl_n_if.slave bus
);
    localparam int UPDATE_CYCLES = (CLOCK_FREQ_HZ / 1000) * UPDATE_MS;
    localparam int BLINK_CYCLES  = (CLOCK_FREQ_HZ / 1000) * BLINK_MS;
    localparam int UW            = $clog2(UPDATE_CYCLES + 1);
    localparam int BW            = $clog2(BLINK_CYCLES + 1);
    localparam int KW            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SCAN_BITS-1:0]    scan_cnt;
    logic [KW-1:0]           k;
    logic [KW-1:0]           k_nxt;
    logic [KW-1:0]           sel;
    logic [4:0]              ghost_cnt;
    logic [UW-1:0]           upd_cnt;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_ph;
    logic [3:0]              dim_q;
    logic [4*NUM_DIGITS-1:0] lat_x;
    logic [NUM_DIGITS-1:0]   lat_dp;
    logic [NUM_DIGITS-1:0]   lat_mask;
    logic [3:0]              nib;
    logic [3:0]              pwm;
    logic                    scan_wrap;
    logic                    upd_wrap;
    logic                    blink_wrap;
    logic                    do_latch;
    logic                    lz_blank;
    logic                    blank;

    function automatic logic [6:0] decode(input logic [3:0] v, input logic hex);
        case (v)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = hex ? 7'h08 : 7'h7F;
            4'hB:    decode = hex ? 7'h03 : 7'h7F;
            4'hC:    decode = hex ? 7'h46 : 7'h7F;
            4'hD:    decode = hex ? 7'h21 : 7'h7F;
            4'hE:    decode = hex ? 7'h06 : 7'h7F;
            default: decode = hex ? 7'h0E : 7'h7F;
        endcase
    endfunction

    assign scan_wrap  = &scan_cnt;
    assign upd_wrap   = (upd_cnt == UW'(UPDATE_CYCLES - 1));
    assign blink_wrap = (blink_cnt == BW'(BLINK_CYCLES - 1));
    assign do_latch   = bus.load_pls || (bus.en && upd_wrap && !bus.freeze);
    assign sel        = KW'(NUM_DIGITS - 1) - k;
    assign nib        = lat_x[4*sel +: 4];
    assign pwm        = scan_cnt[SCAN_BITS-3 -: 4];
    assign bus.dim_val = dim_q;

    // A digit is suppressed only when it and every digit to its left are bare zeros.
    assign lz_blank = bus.lzb_en && (sel != '0) &&
                      ((lat_x >> (4*sel)) == '0) && ((lat_dp >> sel) == '0);

    assign blank = (ghost_cnt != 5'd0) || (pwm > dim_q) || (blink_ph && lat_mask[sel]) ||
                   lz_blank || ((nib > 4'd9) && !bus.hex_mode);

    always_comb begin
        k_nxt = k;
        if (bus.en && scan_wrap)
            k_nxt = (k == KW'(NUM_DIGITS - 1)) ? '0 : k + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            k         <= '0;
            ghost_cnt <= 5'd0;
            upd_cnt   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            dim_q     <= 4'd8;
            lat_x     <= '0;
            lat_dp    <= '0;
            lat_mask  <= '0;
        end else begin
            if (bus.en) begin
                scan_cnt <= scan_cnt + 1'b1;
                k        <= k_nxt;
                // Single-digit builds never change k, so they never blank.
                if (k_nxt != k)
                    ghost_cnt <= 5'(BLANK_CYCLES);
                else if (ghost_cnt != 5'd0)
                    ghost_cnt <= ghost_cnt - 5'd1;
                if (blink_wrap) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            if (bus.load_pls)
                upd_cnt <= '0;
            else if (bus.en)
                upd_cnt <= upd_wrap ? '0 : upd_cnt + 1'b1;
            if (do_latch) begin
                lat_x    <= bus.x;
                lat_dp   <= bus.x_dp;
                lat_mask <= bus.blink_mask;
            end
            if (bus.dim_up_pls && !bus.dim_dwn_pls && dim_q != 4'd15)
                dim_q <= dim_q + 4'd1;
            else if (bus.dim_dwn_pls && !bus.dim_up_pls && dim_q != 4'd0)
                dim_q <= dim_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an  <= '1;
            bus.seg <= 7'h7F;
            bus.dp  <= 1'b1;
        end else if (!bus.en) begin
            bus.an  <= '1;
            bus.seg <= 7'h7F;
            bus.dp  <= 1'b1;
        end else begin
            bus.an  <= ~(NUM_DIGITS'(1) << sel);
            bus.seg <= blank ? 7'h7F : decode(nib, bus.hex_mode);
            bus.dp  <= blank || !lat_dp[sel];
        end
    end
endmodule

// File: tb/tb_seg7_mux_ctrl_n.sv
// Bench for seg7_mux_ctrl_n: a 4-digit and a 3-digit instance share stimulus; a time-based model
// predicts every output each cycle, and directed checks pin down specific display values.
module tb_seg7_mux_ctrl_n;
    localparam int SLOT  = 64;
    localparam int BLANK = 4;
    localparam int UPD   = 20;
    localparam int BLK   = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    seg7_mux_ctrl_n_if #(.NUM_DIGITS(4)) b4 ();
    seg7_mux_ctrl_n_if #(.NUM_DIGITS(3)) b3 ();

    seg7_mux_ctrl_n #(.NUM_DIGITS(4), .CLOCK_FREQ_HZ(1000), .UPDATE_MS(20), .BLINK_MS(50),
                      .SCAN_BITS(6), .BLANK_CYCLES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    seg7_mux_ctrl_n #(.NUM_DIGITS(3), .CLOCK_FREQ_HZ(1000), .UPDATE_MS(20), .BLINK_MS(50),
                      .SCAN_BITS(6), .BLANK_CYCLES(4)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    assign b3.en          = b4.en;
    assign b3.load_pls    = b4.load_pls;
    assign b3.freeze      = b4.freeze;
    assign b3.hex_mode    = b4.hex_mode;
    assign b3.lzb_en      = b4.lzb_en;
    assign b3.dim_up_pls  = b4.dim_up_pls;
    assign b3.dim_dwn_pls = b4.dim_dwn_pls;
    assign b3.x           = b4.x[11:0];
    assign b3.x_dp        = b4.x_dp[2:0];
    assign b3.blink_mask  = b4.blink_mask[2:0];

    // Model state, written in terms of elapsed enabled cycles rather than counters.
    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          nd [2] = '{4, 3};
    int          m_e [2];
    int          m_upd [2];
    int          m_dim [2];
    logic [15:0] m_x [2];
    logic [3:0]  m_dp [2];
    logic [3:0]  m_mask [2];
    logic [3:0]  e_an [2];
    logic [6:0]  e_seg [2];
    logic        e_dp [2];
    logic [3:0]  e_dim [2];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_e[i]    = 0;
            m_upd[i]  = 0;
            m_dim[i]  = 8;
            m_x[i]    = '0;
            m_dp[i]   = '0;
            m_mask[i] = '0;
            e_an[i]   = 4'((1 << nd[i]) - 1);
            e_seg[i]  = 7'h7F;
            e_dp[i]   = 1'b1;
            e_dim[i]  = 4'd8;
        end
    endtask

    task automatic model_step(input int i);
        int         n, s, j;
        logic [3:0] nib;
        bit         blank;
        n   = nd[i];
        s   = m_e[i] % SLOT;
        j   = n - 1 - (m_e[i] / SLOT) % n;
        nib = 4'((m_x[i] >> (4 * j)) & 16'hF);
        blank = (m_e[i] >= SLOT && s < BLANK) ||
                ((s % 16) > m_dim[i]) ||
                (((m_e[i] / BLK) % 2) == 1 && m_mask[i][j]) ||
                (b4.lzb_en && j != 0 && (m_x[i] >> (4 * j)) == 0 && (m_dp[i] >> j) == 0) ||
                (nib > 9 && !b4.hex_mode);
        if (!b4.en) begin
            e_an[i]  = 4'((1 << n) - 1);
            e_seg[i] = 7'h7F;
            e_dp[i]  = 1'b1;
        end else begin
            e_an[i]  = 4'(((1 << n) - 1) & ~(1 << j));
            e_seg[i] = blank ? 7'h7F : dec_tab[nib];
            e_dp[i]  = blank || !m_dp[i][j];
        end
        if (b4.load_pls || (b4.en && (m_upd[i] % UPD) == UPD - 1 && !b4.freeze)) begin
            m_x[i]    = b4.x & 16'((1 << (4 * n)) - 1);
            m_dp[i]   = b4.x_dp & 4'((1 << n) - 1);
            m_mask[i] = b4.blink_mask & 4'((1 << n) - 1);
        end
        if (b4.load_pls) m_upd[i] = 0;
        else if (b4.en)  m_upd[i]++;
        if (b4.en) m_e[i]++;
        if (b4.dim_up_pls && !b4.dim_dwn_pls && m_dim[i] < 15)      m_dim[i]++;
        else if (b4.dim_dwn_pls && !b4.dim_up_pls && m_dim[i] > 0)  m_dim[i]--;
        e_dim[i] = 4'(m_dim[i]);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    always @(negedge clk) begin
        chk("an4",  int'(b4.an),      int'(e_an[0]));
        chk("seg4", int'(b4.seg),     int'(e_seg[0]));
        chk("dp4",  int'(b4.dp),      int'(e_dp[0]));
        chk("dim4", int'(b4.dim_val), int'(e_dim[0]));
        chk("an3",  int'(b3.an),      int'(e_an[1]));
        chk("seg3", int'(b3.seg),     int'(e_seg[1]));
        chk("dp3",  int'(b3.dp),      int'(e_dp[1]));
        chk("dim3", int'(b3.dim_val), int'(e_dim[1]));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load();
        b4.load_pls = 1'b1;
        tick(1);
        b4.load_pls = 1'b0;
    endtask

    task automatic dim_pulses(input bit up, input int n);
        for (int p = 0; p < n; p++) begin
            b4.dim_up_pls  = up;
            b4.dim_dwn_pls = !up;
            tick(1);
            b4.dim_up_pls  = 1'b0;
            b4.dim_dwn_pls = 1'b0;
            tick(1);
        end
    endtask

    task automatic slot_start(input string nm, input logic [3:0] an_t);
        int t = 0;
        while (b4.an == an_t && t < 400) begin tick(1); t++; end
        while (b4.an != an_t && t < 400) begin tick(1); t++; end
        chk({nm, "_wait"}, int'(t < 400), 1);
    endtask

    // Blank exactly BLANK cycles at the start of the slot, then the expected glyph.
    task automatic check_slot(input string nm, input logic [3:0] an_t,
                              input logic [6:0] seg_e, input logic dp_e);
        int blanks = 0;
        slot_start(nm, an_t);
        for (int c = 0; c < 8; c++) begin
            if (b4.seg == 7'h7F) blanks++;
            tick(1);
        end
        chk({nm, "_blank"}, blanks, BLANK);
        chk({nm, "_seg"}, int'(b4.seg), int'(seg_e));
        chk({nm, "_dp"}, int'(b4.dp), int'(dp_e));
    endtask

    task automatic lit_frame(output logic [3:0] lit);
        lit = '0;
        for (int c = 0; c < 4 * SLOT; c++) begin
            if (b4.seg != 7'h7F) lit |= ~b4.an;
            tick(1);
        end
    endtask

    initial begin
        logic [3:0] lit;
        int         t, len, cnt;
        b4.en = 1'b0; b4.load_pls = 1'b0; b4.freeze = 1'b0; b4.hex_mode = 1'b0;
        b4.lzb_en = 1'b0; b4.dim_up_pls = 1'b0; b4.dim_dwn_pls = 1'b0;
        b4.x = '0; b4.x_dp = '0; b4.blink_mask = '0;
        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_dim", int'(b4.dim_val), 8);
        chk("rst_an",  int'(b4.an), 'hF);
        chk("rst_seg", int'(b4.seg), 'h7F);
        chk("rst_dp",  int'(b4.dp), 1);
        rst_n = 1'b1;
        b4.en = 1'b1;

        dim_pulses(1'b1, 10);
        chk("dim_sat_hi", int'(b4.dim_val), 15);
        b4.dim_up_pls = 1'b1; b4.dim_dwn_pls = 1'b1;
        tick(1);
        b4.dim_up_pls = 1'b0; b4.dim_dwn_pls = 1'b0;
        tick(1);
        chk("dim_both", int'(b4.dim_val), 15);

        b4.x = 16'h1234;
        load();
        check_slot("d3_1", 4'b0111, 7'h79, 1'b1);
        check_slot("d2_2", 4'b1011, 7'h24, 1'b1);
        check_slot("d1_3", 4'b1101, 7'h30, 1'b1);
        check_slot("d0_4", 4'b1110, 7'h19, 1'b1);

        // dim 0: pwm==0 at slot offsets 0,16,32,48; offset 0 falls in the anti-ghost window.
        dim_pulses(1'b0, 16);
        chk("dim_sat_lo", int'(b4.dim_val), 0);
        slot_start("dim0", 4'b1011);
        len = 0; cnt = 0;
        while (b4.an == 4'b1011 && len < 100) begin
            if (b4.seg != 7'h7F) cnt++;
            len++;
            tick(1);
        end
        chk("dim0_lit", cnt, 3);
        chk("slot_len", len, SLOT);
        dim_pulses(1'b1, 16);

        b4.x = 16'h5678;
        tick(30);
        b4.freeze = 1'b1;
        b4.x = 16'h9993;
        tick(60);
        check_slot("frz_d0", 4'b1110, 7'h00, 1'b1);
        load();
        chk("load_n1", int'(b4.seg), 'h00);
        tick(1);
        chk("load_1clk", int'(b4.seg), 'h30);
        b4.freeze = 1'b0;

        b4.lzb_en = 1'b1;
        b4.x = 16'h0005; b4.x_dp = 4'b0000;
        load();
        tick(2);
        lit_frame(lit);
        chk("lzb_only_d0", int'(lit), 'b0001);
        b4.x_dp = 4'b0010;
        load();
        check_slot("lzb_dp", 4'b1101, 7'h40, 1'b0);
        b4.x = 16'h00A5; b4.x_dp = 4'b0000;
        load();
        tick(2);
        lit_frame(lit);
        chk("nohex_a", int'(lit), 'b0001);

        b4.lzb_en = 1'b0; b4.hex_mode = 1'b1;
        b4.x = 16'hABCD;
        load();
        check_slot("hex_a", 4'b0111, 7'h08, 1'b1);
        check_slot("hex_b", 4'b1011, 7'h03, 1'b1);
        check_slot("hex_c", 4'b1101, 7'h46, 1'b1);
        check_slot("hex_d", 4'b1110, 7'h21, 1'b1);

        b4.blink_mask = 4'b0001;
        load();
        tick(250);

        t = 0;
        while (b3.an == 3'b110 && t < 400) begin tick(1); t++; end
        while (b3.an != 3'b110 && t < 400) begin tick(1); t++; end
        chk("n3_wait", int'(t < 400), 1);
        len = 0;
        while (b3.an == 3'b110 && len < 100) begin len++; tick(1); end
        chk("n3_len", len, SLOT);
        chk("n3_wrap", int'(b3.an), 'b011);

        t = 0;
        while (b3.an == 3'b101 && t < 400) begin tick(1); t++; end
        while (b3.an != 3'b101 && t < 400) begin tick(1); t++; end
        chk("en_wait", int'(t < 400), 1);
        tick(10);
        b4.en = 1'b0;
        tick(1);
        chk("en_lo_an3", int'(b3.an), 'b111);
        chk("en_lo_seg3", int'(b3.seg), 'h7F);
        chk("en_lo_an4", int'(b4.an), 'hF);
        tick(20);
        b4.en = 1'b1;
        tick(1);
        chk("en_resume", int'(b3.an), 'b101);

        tick(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dim", int'(b4.dim_val), 8);
        chk("arst_an",  int'(b4.an), 'hF);
        chk("arst_seg", int'(b4.seg), 'h7F);
        tick(2);
        rst_n = 1'b1;
        tick(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
